wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Schedules the single register-file write port between the pipeline write-back path and a long-latency result unit (multiply/divide). Pipeline write-back results arrive as already selected by the MemtoReg mux. Long-latency results are buffered in a small FIFO and drained on cycles the pipeline does not write. An optional starvation guard stalls the pipeline for one cycle to force a drain.

## Interface
- B, 32, data width
- D, 5, register address width
- DEPTH, 4, long-latency FIFO entries (power of two, ≥2)
- MAX_WAIT, 8, consecutive cycles a non-empty FIFO head may go unserved before a forced drain (≥1)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- wb_valid  in  1  pipeline write-back request (RegWrite of the WB stage)
- wb_dst  in  D  pipeline destination register
- wb_data  in  B  pipeline write data (write-back mux output)
- lu_valid  in  1  long-latency result valid
- lu_dst  in  D  long-latency destination register
- lu_data  in  B  long-latency result
- lu_ready  out  1  FIFO can accept; lu transfer occurs when lu_valid && lu_ready
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  D  register-file write address (registered)
- rf_wdata  out  B  register-file write data (registered)
- stall  out  1  pipeline freeze request (registered); WB inputs must be held stable while high
- pend_mask  out  2^D  bit r set iff any FIFO entry targets register r

## Operation
- Each cycle, at most one source is selected and registered onto rf_*:
  - If stall=1 and the FIFO is non-empty: pop the FIFO head. wb_valid is ignored this cycle.
  - Else if wb_valid=1 and wb_dst≠0: select the pipeline.
  - Else if the FIFO is non-empty: pop the head.
  - Else: rf_we←0. rf_waddr and rf_wdata hold their previous values.
- Register 0 filtering:
  - wb_valid with wb_dst=0 is dropped and counts as an idle pipeline cycle.
  - A lu transfer with lu_dst=0 is consumed (lu_ready honoured) but not enqueued.
- FIFO:
  - Circular buffer with read/write pointers and a count of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
  - lu_ready = (count < DEPTH). It is computed from registered count only, so when full it stays 0 even during a pop cycle.
  - Push and pop in the same cycle leave count unchanged.
- pend_mask: combinational OR of one-hot decodes of every valid entry's destination.
- Ordering between pipeline and FIFO writes to the same register is not resolved here. The hazard unit uses pend_mask to stall dependent instructions.
- Starvation guard:
  - wait_cnt increments each cycle the FIFO is non-empty and no pop occurs. It clears on any pop or when the FIFO is empty.
  - When wait_cnt reaches MAX_WAIT, stall is set for exactly one cycle. During that cycle the head is popped, and both wait_cnt and stall clear at the next edge.

## Timing
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, stall=0, lu_ready=1, pend_mask=0, count=0, pointers=0, wait_cnt=0.
- Pipeline latency: wb inputs in cycle N appear on rf_* in cycle N+1.
- Long-latency latency: a transfer in cycle N is enqueued at edge N. Its earliest appearance on rf_* is cycle N+2, with no bypass.
- stall is high for one cycle per starvation event. Consecutive stall cycles never occur, because the pop resets wait_cnt.
- Reset mid-operation discards all FIFO contents and any pending stall immediately. The rf_* outputs drop to their reset values asynchronously.

## Configuration
- WB_STARVE_GUARD_EN defined: wait_cnt and stall logic are present as described.
- WB_STARVE_GUARD_EN undefined:
  - stall is tied to 0 and wait_cnt is not built.
  - The FIFO drains only on cycles without a pipeline write, so it can starve indefinitely under continuous write-back.

## Test plan
- Reset, then lu transfer {dst=3, data=0xAAAA0003} with wb_valid=0 → rf_we=1, rf_waddr=3, rf_wdata=0xAAAA0003 two cycles later; pend_mask bit 3 high for one cycle.
- wb_valid={dst=5, 0x55} held continuously while lu pushes {dst=7, 0x77} → rf writes reg 5 every cycle. With the guard, stall pulses 9 cycles after the push and reg 7←0x77 in the next cycle. Without the guard, reg 7 is never written.
- Push DEPTH=4 entries with wb_valid=1 → lu_ready=0 after the 4th. A 5th lu_valid is held off until a drain, then is accepted with order preserved.
- lu {dst=0} and wb {dst=0} → no enqueue, rf_we stays 0, pend_mask stays 0.
- Simultaneous push and pop at count=2 → count stays 2, data order is FIFO, and pointers wrap correctly after 6 such cycles.
- Assert reset with 3 entries queued and stall=1 → all outputs go to reset values immediately, and no queued write appears after reset release.

Source files
------------

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle for wb_port_arbiter: pipeline write-back, long-latency result
// push, register-file write port, stall request and debug state.
interface wb_port_arbiter_if #(
  parameter int B     = 32,
  parameter int D     = 5,
  parameter int DEPTH = 4
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  // Handshake: wb_valid has no back-pressure except through stall (the
  // pipeline freezes its WB inputs while stall is high). A long-latency
  // result transfers on a rising edge where lu_valid && lu_ready; lu_valid
  // and lu_dst/lu_data must stay stable until that edge.
  logic            wb_valid;
  logic [D-1:0]    wb_dst;
  logic [B-1:0]    wb_data;
  logic            lu_valid;
  logic [D-1:0]    lu_dst;
  logic [B-1:0]    lu_data;
  logic            lu_ready;
  logic            rf_we;
  logic [D-1:0]    rf_waddr;
  logic [B-1:0]    rf_wdata;
  logic            stall;
  logic [2**D-1:0] pend_mask;
  logic [CW-1:0]   dbg_count;
  logic [AW-1:0]   dbg_rd_ptr;
  logic [AW-1:0]   dbg_wr_ptr;

  modport slave (
    input  wb_valid, wb_dst, wb_data, lu_valid, lu_dst, lu_data,
    output lu_ready, rf_we, rf_waddr, rf_wdata, stall, pend_mask,
           dbg_count, dbg_rd_ptr, dbg_wr_ptr
  );

  modport master (
    output wb_valid, wb_dst, wb_data, lu_valid, lu_dst, lu_data,
    input  lu_ready, rf_we, rf_waddr, rf_wdata, stall, pend_mask,
           dbg_count, dbg_rd_ptr, dbg_wr_ptr
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: pipeline write-back has priority, long-latency
// results queue in a FIFO. Define WB_STARVE_GUARD_EN to build the starvation guard.
module wb_port_arbiter #(
  parameter int B        = 32,
  parameter int D        = 5,
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input logic              clk,
  input logic              reset,
  wb_port_arbiter_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [D-1:0]    dst_mem  [DEPTH];
  logic [B-1:0]    data_mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            fifo_ne;
  logic            wb_req;
  logic            push;
  logic            pop;
  logic            wb_sel;
  logic            stall_q;
  logic [2**D-1:0] pend;
  logic [AW-1:0]   off;

  assign fifo_ne      = (count != '0);
  assign bus.lu_ready = (count < CW'(DEPTH));
  assign wb_req       = bus.wb_valid && (bus.wb_dst != '0);
  // Writes to r0 are consumed but never queued.
  assign push         = bus.lu_valid && bus.lu_ready && (bus.lu_dst != '0);
  // A stall forces the head out even when the pipeline asks for the port.
  assign pop          = fifo_ne && (stall_q || !wb_req);
  assign wb_sel       = wb_req && !pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      bus.rf_we    <= 1'b0;
      bus.rf_waddr <= '0;
      bus.rf_wdata <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop) begin
        bus.rf_we    <= 1'b1;
        bus.rf_waddr <= dst_mem[rd_ptr];
        bus.rf_wdata <= data_mem[rd_ptr];
      end else if (wb_sel) begin
        bus.rf_we    <= 1'b1;
        bus.rf_waddr <= bus.wb_dst;
        bus.rf_wdata <= bus.wb_data;
      end else begin
        bus.rf_we    <= 1'b0;
      end
    end
  end

  // Entry storage needs no reset: validity comes from count and rd_ptr.
  always_ff @(posedge clk) begin
    if (push) begin
      dst_mem[wr_ptr]  <= bus.lu_dst;
      data_mem[wr_ptr] <= bus.lu_data;
    end
  end

  // An entry is live when its distance from the head is below count.
  always_comb begin
    pend = '0;
    off  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd_ptr;
      if ({1'b0, off} < count) pend[dst_mem[i]] = 1'b1;
    end
  end

  assign bus.pend_mask  = pend;
  assign bus.dbg_count  = count;
  assign bus.dbg_rd_ptr = rd_ptr;
  assign bus.dbg_wr_ptr = wr_ptr;

`ifdef WB_STARVE_GUARD_EN
  localparam int WW = $clog2(MAX_WAIT + 1);
  logic [WW-1:0] wait_cnt;
  logic [WW-1:0] wait_nxt;

  always_comb begin
    wait_nxt = '0;
    if (fifo_ne && !pop) wait_nxt = wait_cnt + 1'b1;
  end

  // Stall rises on the edge where the wait reaches MAX_WAIT; the pop it
  // forces clears wait_cnt, so stall never stays high two cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      stall_q  <= 1'b0;
    end else begin
      wait_cnt <= wait_nxt;
      stall_q  <= (wait_nxt == WW'(MAX_WAIT));
    end
  end
`else
  assign stall_q = 1'b0;
`endif

  assign bus.stall = stall_q;
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: vector table plus hand-written sequences
// for starvation, FIFO full, pointer wrap and mid-operation reset.
module tb_wb_port_arbiter;
  localparam int B = 32, D = 5, DEPTH = 4, MAX_WAIT = 8;
`ifdef WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.B(B), .D(D), .DEPTH(DEPTH)) bus ();
  wb_port_arbiter #(.B(B), .D(D), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic        wv;
    logic [4:0]  wd;
    logic [31:0] wdat;
    logic        lv;
    logic [4:0]  ld;
    logic [31:0] ldat;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_rdy;
    logic [31:0] e_pend;
    logic [2:0]  e_cnt;
  } vec_t;

  vec_t        vt [10];
  logic [36:0] exp_q [$];
  int          n_chk  = 0;
  int          n_pass = 0;
  bit          found;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wv, input logic [4:0] wd, input logic [31:0] wdat,
                       input logic lv, input logic [4:0] ld, input logic [31:0] ldat);
    bus.wb_valid = wv; bus.wb_dst = wd; bus.wb_data = wdat;
    bus.lu_valid = lv; bus.lu_dst = ld; bus.lu_data = ldat;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  // Any non-pipeline write (pipeline uses r5 in these sequences) must be the queue head.
  task automatic sb_check(input string name);
    if (bus.rf_we && bus.rf_waddr != 5'd5) begin
      if (exp_q.size() == 0) chk({name, "_unexpected"}, {bus.rf_waddr, bus.rf_wdata}, 37'h0);
      else chk(name, {bus.rf_waddr, bus.rf_wdata}, exp_q.pop_front());
    end
  endtask

  initial begin
    //        wv wd    wdat          lv ld     ldat           we addr  data           rdy pend          cnt
    vt[0] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd3,  32'hAAAA0003, 1'b0, 5'd0,  32'h0,        1'b1, 32'h0000_0008, 3'd1};
    vt[1] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'hAAAA0003, 1'b1, 32'h0,         3'd0};
    vt[2] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,        1'b0, 5'd3,  32'hAAAA0003, 1'b1, 32'h0,         3'd0};
    vt[3] = '{1'b1, 5'd5, 32'h55, 1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  32'h55,       1'b1, 32'h0,         3'd0};
    vt[4] = '{1'b1, 5'd0, 32'h99, 1'b1, 5'd0,  32'h11,       1'b0, 5'd5,  32'h55,       1'b1, 32'h0,         3'd0};
    vt[5] = '{1'b1, 5'd6, 32'h66, 1'b1, 5'd7,  32'h77,       1'b1, 5'd6,  32'h66,       1'b1, 32'h0000_0080, 3'd1};
    vt[6] = '{1'b1, 5'd8, 32'h88, 1'b1, 5'd9,  32'h99,       1'b1, 5'd8,  32'h88,       1'b1, 32'h0000_0280, 3'd2};
    vt[7] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h77,       1'b1, 32'h0000_0200, 3'd1};
    vt[8] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd10, 32'hA0,       1'b1, 5'd9,  32'h99,       1'b1, 32'h0000_0400, 3'd1};
    vt[9] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 32'hA0,       1'b1, 32'h0,         3'd0};

    // Reset values
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    cyc();
    cyc();
    chk("rst_we", bus.rf_we, 0);
    chk("rst_waddr", bus.rf_waddr, 0);
    chk("rst_wdata", bus.rf_wdata, 0);
    chk("rst_stall", bus.stall, 0);
    chk("rst_ready", bus.lu_ready, 1);
    chk("rst_pend", bus.pend_mask, 0);
    chk("rst_count", bus.dbg_count, 0);
    chk("rst_ptrs", {bus.dbg_rd_ptr, bus.dbg_wr_ptr}, 0);
    reset = 1'b0;

    // Vector table
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].wv, vt[i].wd, vt[i].wdat, vt[i].lv, vt[i].ld, vt[i].ldat);
      cyc();
      chk($sformatf("v%0d_we", i), bus.rf_we, vt[i].e_we);
      chk($sformatf("v%0d_waddr", i), bus.rf_waddr, vt[i].e_addr);
      chk($sformatf("v%0d_wdata", i), bus.rf_wdata, vt[i].e_data);
      chk($sformatf("v%0d_ready", i), bus.lu_ready, vt[i].e_rdy);
      chk($sformatf("v%0d_pend", i), bus.pend_mask, vt[i].e_pend);
      chk($sformatf("v%0d_count", i), bus.dbg_count, vt[i].e_cnt);
    end

    // Starvation: continuous write-back to r5, one queued result for r7
    do_reset();
    drive(1, 5, 32'h55, 1, 7, 32'h77);
    cyc();
    chk("starve_push_waddr", bus.rf_waddr, 5);
    chk("starve_push_count", bus.dbg_count, 1);
    drive(1, 5, 32'h55, 0, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk($sformatf("starve_k%0d_stall", k), bus.stall, (GUARD && k == 8) ? 1 : 0);
      chk($sformatf("starve_k%0d_waddr", k), bus.rf_waddr, (GUARD && k == 9) ? 7 : 5);
      chk($sformatf("starve_k%0d_wdata", k), bus.rf_wdata, (GUARD && k == 9) ? 32'h77 : 32'h55);
    end
    chk("starve_count", bus.dbg_count, GUARD ? 0 : 1);
    drive(0, 0, 0, 0, 0, 0);
    cyc();
    chk("starve_drain_we", bus.rf_we, GUARD ? 0 : 1);
    if (!GUARD) chk("starve_drain_waddr", bus.rf_waddr, 7);
    chk("starve_drain_count", bus.dbg_count, 0);

    // FIFO full and back-pressure on the fifth result
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back({5'(11 + i), 32'hB000_0000 + 32'(11 + i)});
    for (int s = 1; s <= 12; s++) begin
      logic [2:0] e_cnt;
      logic       e_rdy;
      logic       lv;
      logic [4:0] ld;
      case (s)
        1, 2, 3, 4: begin lv = 1; ld = 5'(10 + s); end
        5, 6, 7, 8: begin lv = 1; ld = 5'd15; end
        default:    begin lv = 0; ld = 5'd0; end
      endcase
      case (s)
        1: e_cnt = 1; 2: e_cnt = 2; 3: e_cnt = 3; 4, 5, 6: e_cnt = 4;
        7, 8: e_cnt = 3; 9: e_cnt = 2; 10: e_cnt = 1; default: e_cnt = 0;
      endcase
      e_rdy = (s >= 4 && s <= 6) ? 0 : 1;
      drive(s <= 6, 5'd5, 32'h55, lv, ld, 32'hB000_0000 + 32'(ld));
      cyc();
      chk($sformatf("full_s%0d_count", s), bus.dbg_count, e_cnt);
      chk($sformatf("full_s%0d_ready", s), bus.lu_ready, e_rdy);
      chk($sformatf("full_s%0d_stall", s), bus.stall, 0);
      sb_check($sformatf("full_s%0d_order", s));
    end
    chk("full_idle_we", bus.rf_we, 0);
    chk("full_queue_empty", exp_q.size(), 0);

    // Simultaneous push/pop at count=2 across pointer wrap
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back({5'(16 + i), 32'hC000_0000 + 32'(16 + i)});
    for (int s = 0; s < 10; s++) begin
      logic [4:0] ld;
      ld = 5'(16 + s);
      drive(s < 2, 5'd5, 32'h55, s < 8, (s < 8) ? ld : 5'd0, 32'hC000_0000 + 32'(ld));
      cyc();
      if (s >= 1 && s <= 7) chk($sformatf("wrap_s%0d_count", s), bus.dbg_count, 2);
      sb_check($sformatf("wrap_s%0d_order", s));
      if (s == 7) chk("wrap_ptrs", {bus.dbg_rd_ptr, bus.dbg_wr_ptr}, {2'd2, 2'd0});
    end
    chk("wrap_end_count", bus.dbg_count, 0);
    chk("wrap_end_ptrs", {bus.dbg_rd_ptr, bus.dbg_wr_ptr}, {2'd0, 2'd0});
    chk("wrap_queue_empty", exp_q.size(), 0);

    // Reset with three entries queued (and stall high when the guard exists)
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 5, 32'h55, 1, 5'(24 + i), 32'hD000_0000 + 32'(i));
      cyc();
    end
    drive(1, 5, 32'h55, 0, 0, 0);
    if (GUARD) begin
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
        cyc();
        found = bus.stall;
      end
      chk("mid_stall_seen", found, 1);
    end else begin
      for (int k = 0; k < 8; k++) cyc();
    end
    chk("mid_pend", bus.pend_mask, 32'h0700_0000);
    chk("mid_waddr_before", bus.rf_waddr, 5);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_we", bus.rf_we, 0);
    chk("mid_rst_waddr", bus.rf_waddr, 0);
    chk("mid_rst_wdata", bus.rf_wdata, 0);
    chk("mid_rst_stall", bus.stall, 0);
    chk("mid_rst_ready", bus.lu_ready, 1);
    chk("mid_rst_pend", bus.pend_mask, 0);
    chk("mid_rst_count", bus.dbg_count, 0);
    drive(0, 0, 0, 0, 0, 0);
    cyc();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk($sformatf("post_rst_k%0d_we", k), bus.rf_we, 0);
      chk($sformatf("post_rst_k%0d_count", k), bus.dbg_count, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
